mcs51_serial: RTL and testbench

Serial-port peripheral for the `mcs51_mcu` SFR bus, implementing the 8051 UART in modes 1 and 3. It sits directly downstream of the core's SFR write path and upstream of the P3.0/P3.1 pin muxing. It consumes SCON/SBUF writes and Timer 1 overflow pulses. It produces `txd_out`, received bytes readable through SBUF, and the RI/TI interrupt request.

---
 rtl/mcs51_pkg.sv | 26 ++
 rtl/mcs51_uart_rx.sv | 109 ++++++++++
 rtl/mcs51_serial.sv | 150 +++++++++++++++
 tb/tb_mcs51_serial.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcs51_pkg.sv
// Shared definitions for the mcs51 serial port.
// Holds the SFR addresses of SCON and SBUF, the SCON bit positions and the
// state set used by both the transmit and the receive state machines.
package mcs51_pkg;

  localparam logic [7:0] SFR_SCON = 8'h98;
  localparam logic [7:0] SFR_SBUF = 8'h99;

  localparam int SCON_RI  = 0;
  localparam int SCON_TI  = 1;
  localparam int SCON_RB8 = 2;
  localparam int SCON_TB8 = 3;
  localparam int SCON_REN = 4;
  localparam int SCON_SM2 = 5;
  localparam int SCON_SM1 = 6;
  localparam int SCON_SM0 = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    BIT9,
    STOP
  } uart_state_e;

endpackage

// File: rtl/mcs51_uart_rx.sv
// Receive half of the mcs51 UART.
// Synchronizes rxd, detects the start edge on an oversample tick, takes a
// 2-of-3 vote at ticks 7/8/9 of every bit and walks START/DATA/[BIT9]/STOP.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   tick            oversample tick (16 per bit)
//   en              receiver enable (SCON.REN); dropping it aborts a frame
//   nine_bit        1 = frame carries a 9th bit before the stop bit
//   rxd             asynchronous serial input
//   data            received byte, LSB first on the line
//   bit9            received 9th bit (valid in 9-bit mode)
//   stop_bit        voted value of the stop bit
//   frame_done      one-cycle pulse after the stop bit has been sampled
module mcs51_uart_rx
  import mcs51_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       en,
  input  logic       nine_bit,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       bit9,
  output logic       stop_bit,
  output logic       frame_done
);

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic                   rx_last;
  uart_state_e            state, state_next;
  logic [3:0]             cnt;
  logic [2:0]             bits;
  logic                   s7, s8;
  logic                   sample_pt, bit_end, maj, done;

  assign rx_s = sync[SYNC_STAGES-1];

  always_comb begin
    state_next = state;
    done       = 1'b0;
    sample_pt  = tick && (cnt == 4'd9);
    bit_end    = tick && (cnt == 4'd15);
    maj        = majority3(s7, s8, rx_s);
    case (state)
      IDLE:  if (tick && rx_last && !rx_s) state_next = START;
      START: begin
        // A start bit that votes high was noise: drop back silently.
        if (sample_pt && maj) state_next = IDLE;
        else if (bit_end)     state_next = DATA;
      end
      DATA:  if (bit_end && bits == 3'd7) state_next = nine_bit ? BIT9 : STOP;
      BIT9:  if (bit_end) state_next = STOP;
      STOP: begin
        // Frame ends at the stop-bit vote, not at the end of the stop bit.
        if (sample_pt) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!en) begin
      state_next = IDLE;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync       <= '1;
      rx_last    <= 1'b1;
      state      <= IDLE;
      cnt        <= 4'd0;
      bits       <= 3'd0;
      frame_done <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], rxd};
      state      <= state_next;
      frame_done <= done;
      if (tick) rx_last <= rx_s;
      // The detecting tick is tick 0 of the start bit, so the count leaves
      // IDLE already at 1.
      if (state == IDLE) begin
        cnt  <= 4'd1;
        bits <= 3'd0;
      end else if (tick) begin
        cnt <= cnt + 4'd1;
        if (bit_end && state == DATA) bits <= bits + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tick && cnt == 4'd7) s7 <= rx_s;
    if (tick && cnt == 4'd8) s8 <= rx_s;
    if (sample_pt && state == DATA) data <= {maj, data[7:1]};
    if (sample_pt && state == BIT9) bit9 <= maj;
    if (done) stop_bit <= maj;
  end

endmodule

// File: rtl/mcs51_serial.sv
// 8051 serial port (UART modes 1 and 3) on the SFR bus.
// Holds SCON, the receive buffer, the frame acceptance rule, the transmit
// state machine and the Timer 1 baud prescaler; reception is delegated to
// mcs51_uart_rx.
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   sfr_addr/sfr_wr/sfr_wdata     SFR write port (SCON 0x98, SBUF 0x99)
//   sfr_rdata, sfr_sel            combinational SFR read data and select
//   t1_ovf                        Timer 1 overflow pulse
//   smod                          PCON.7 baud doubler
//   rxd_in, txd_out               serial line in / out (out idles high)
//   irq                           RI | TI
module mcs51_serial
  import mcs51_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sfr_addr,
  input  logic       sfr_wr,
  input  logic [7:0] sfr_wdata,
  output logic [7:0] sfr_rdata,
  output logic       sfr_sel,
  input  logic       t1_ovf,
  input  logic       smod,
  input  logic       rxd_in,
  output logic       txd_out,
  output logic       irq
);

  logic [7:0]  scon, rbuf, tx_shift;
  logic        presc, tick;
  logic        wr_scon, wr_sbuf, tx_accept, tx_pending;
  uart_state_e tx_state, tx_next;
  logic [3:0]  tx_cnt;
  logic [2:0]  tx_bits, tx_bits_next;
  logic        tx_bit_end, tx_level, ti_set;
  logic [7:0]  rx_data;
  logic        rx_bit9, rx_stop, rx_done, accept, rb8_val;

  // Without the doubler only every second overflow becomes a tick.
  assign tick    = t1_ovf & (smod | presc);
  assign wr_scon = sfr_wr && (sfr_addr == SFR_SCON);
  assign wr_sbuf = sfr_wr && (sfr_addr == SFR_SBUF);
  assign sfr_sel = (sfr_addr == SFR_SCON) || (sfr_addr == SFR_SBUF);
  assign irq     = scon[SCON_TI] | scon[SCON_RI];

  always_comb begin
    sfr_rdata = 8'h00;
    case (sfr_addr)
      SFR_SCON: sfr_rdata = scon;
      SFR_SBUF: sfr_rdata = rbuf;
      default:  sfr_rdata = 8'h00;
    endcase
  end

  always_comb begin
    tx_next    = tx_state;
    tx_bit_end = tick && (tx_cnt == 4'd15);
    case (tx_state)
      IDLE:  if (tick && tx_pending) tx_next = START;
      START: if (tx_bit_end) tx_next = DATA;
      DATA:  if (tx_bit_end && tx_bits == 3'd7) tx_next = scon[SCON_SM0] ? BIT9 : STOP;
      BIT9:  if (tx_bit_end) tx_next = STOP;
      STOP:  if (tx_bit_end) tx_next = IDLE;
      default: tx_next = IDLE;
    endcase
    // A byte written on the very tick that launches the frame would race the
    // frame already latched, so only a quiet IDLE accepts a new byte.
    tx_accept    = wr_sbuf && (tx_state == IDLE) && (tx_next != START);
    ti_set       = (tx_next == STOP) && (tx_state != STOP);
    tx_bits_next = tx_bits;
    if (tx_state == DATA && tx_bit_end) tx_bits_next = tx_bits + 3'd1;
    // txd_out is registered, so it is driven from the upcoming state.
    tx_level = 1'b1;
    case (tx_next)
      START:   tx_level = 1'b0;
      DATA:    tx_level = tx_shift[tx_bits_next];
      BIT9:    tx_level = scon[SCON_TB8];
      default: tx_level = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc      <= 1'b0;
      tx_state   <= IDLE;
      tx_cnt     <= 4'd0;
      tx_bits    <= 3'd0;
      tx_pending <= 1'b0;
      txd_out    <= 1'b1;
    end else begin
      presc    <= presc ^ (t1_ovf & ~smod);
      tx_state <= tx_next;
      txd_out  <= tx_level;
      if (tx_state == IDLE) begin
        tx_cnt  <= 4'd0;
        tx_bits <= 3'd0;
        if (tx_next == START) tx_pending <= 1'b0;
        else if (tx_accept)   tx_pending <= 1'b1;
      end else begin
        tx_bits <= tx_bits_next;
        if (tick) tx_cnt <= tx_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_accept) tx_shift <= sfr_wdata;
  end

  mcs51_uart_rx #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .en        (scon[SCON_REN]),
    .nine_bit  (scon[SCON_SM0]),
    .rxd       (rxd_in),
    .data      (rx_data),
    .bit9      (rx_bit9),
    .stop_bit  (rx_stop),
    .frame_done(rx_done)
  );

  // Multiprocessor filter: with SM2 set only frames whose RB8 candidate is 1
  // get through; a pending RI always blocks the new frame.
  assign rb8_val = scon[SCON_SM0] ? rx_bit9 : rx_stop;
  assign accept  = rx_done && !scon[SCON_RI] && (!scon[SCON_SM2] || rb8_val);

  // Later assignments win: a core write overrides RB8, hardware TI/RI sets
  // override the core write for those two bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      scon <= 8'h00;
      rbuf <= 8'h00;
    end else begin
      if (accept) begin
        rbuf           <= rx_data;
        scon[SCON_RB8] <= rb8_val;
      end
      if (wr_scon) scon <= sfr_wdata;
      if (ti_set)  scon[SCON_TI] <= 1'b1;
      if (accept)  scon[SCON_RI] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mcs51_serial.sv
// Directed-plus-random bench for mcs51_serial with t1_ovf held high.
module tb_mcs51_serial;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sfr_addr;
  logic       sfr_wr;
  logic [7:0] sfr_wdata;
  logic [7:0] sfr_rdata;
  logic       sfr_sel;
  logic       t1_ovf;
  logic       smod;
  logic       rxd_in;
  logic       txd_out;
  logic       irq;

  int checks = 0;
  int errors = 0;

  // Reference state: what SCON and the receive buffer should hold.
  logic [7:0] m_scon;
  logic [7:0] m_rbuf;

  mcs51_serial #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .sfr_addr (sfr_addr),
    .sfr_wr   (sfr_wr),
    .sfr_wdata(sfr_wdata),
    .sfr_rdata(sfr_rdata),
    .sfr_sel  (sfr_sel),
    .t1_ovf   (t1_ovf),
    .smod     (smod),
    .rxd_in   (rxd_in),
    .txd_out  (txd_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
    sfr_addr  = a;
    sfr_wdata = d;
    sfr_wr    = 1'b1;
    @(posedge clk);
    #1;
    sfr_wr   = 1'b0;
    sfr_addr = 8'h00;
  endtask

  task automatic sfr_read(input logic [7:0] a, output logic [7:0] d);
    sfr_addr = a;
    #1;
    d = sfr_rdata;
    sfr_addr = 8'h00;
  endtask

  // Sends one byte and checks the line level every clock against the
  // expected frame, plus the TI timing around the start of the stop bit.
  task automatic check_tx(input logic [7:0] b, input logic nine, input logic tb8,
                          input int blen, input bit check_lat);
    logic [10:0] frame;
    int nb, waited;
    nb    = nine ? 11 : 10;
    frame = nine ? {1'b1, tb8, b, 1'b0} : {2'b11, b, 1'b0};
    sfr_write(8'h99, b);
    waited = 0;
    while (txd_out !== 1'b0 && waited < 100) begin
      step(1);
      waited++;
    end
    check1("tx_start_seen", txd_out, 1'b0);
    if (check_lat) check_int("tx_start_latency", waited, 1);
    for (int k = 0; k < nb * blen; k++) begin
      check1("tx_bit", txd_out, frame[k / blen]);
      if (k == (nb - 1) * blen - 1) check1("irq_before_stop", irq, 1'b0);
      if (k == (nb - 1) * blen)     check1("irq_at_stop", irq, 1'b1);
      step(1);
    end
  endtask

  task automatic drive_bits(input logic [10:0] frame, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rxd_in = frame[i];
      step(16);
    end
  endtask

  // Writes SCON, sends one frame on rxd and applies the acceptance rule to
  // the reference state before comparing SCON and the receive buffer.
  task automatic rx_case(input logic [7:0] scon_w, input logic [7:0] b,
                         input logic b9, input logic stopb);
    logic [10:0] frame;
    logic [7:0]  rd;
    logic        sm0, sm2, cand;
    int          nb;
    sfr_write(8'h98, scon_w);
    m_scon = scon_w;
    sm0    = scon_w[7];
    sm2    = scon_w[5];
    cand   = sm0 ? b9 : stopb;
    if (sm0) begin
      frame = {stopb, b9, b, 1'b0};
      nb    = 11;
    end else begin
      frame = {1'b1, stopb, b, 1'b0};
      nb    = 10;
    end
    drive_bits(frame, 0, nb - 1);
    rxd_in = 1'b1;
    step(6);
    if (scon_w[4] && !m_scon[0] && (!sm2 || cand)) begin
      m_rbuf    = b;
      m_scon[2] = cand;
      m_scon[0] = 1'b1;
    end
    sfr_read(8'h99, rd);
    check8("rx_sbuf", rd, m_rbuf);
    sfr_read(8'h98, rd);
    check8("rx_scon", rd, m_scon);
    check1("rx_irq", irq, m_scon[0] | m_scon[1]);
  endtask

  initial begin
    logic [7:0]  rd;
    logic [7:0]  b;
    logic [7:0]  sw;
    logic [10:0] frame;
    logic        tb8, b9, stopb;

    reset     = 1'b1;
    sfr_addr  = 8'h00;
    sfr_wr    = 1'b0;
    sfr_wdata = 8'h00;
    t1_ovf    = 1'b1;
    smod      = 1'b1;
    rxd_in    = 1'b1;
    m_scon    = 8'h00;
    m_rbuf    = 8'h00;

    // Reset state
    step(3);
    reset = 1'b0;
    check1("reset_txd", txd_out, 1'b1);
    check1("reset_irq", irq, 1'b0);
    sfr_read(8'h98, rd);
    check8("reset_scon", rd, 8'h00);
    sfr_read(8'h99, rd);
    check8("reset_sbuf", rd, 8'h00);
    sfr_addr = 8'h98;
    #1 check1("sel_scon", sfr_sel, 1'b1);
    sfr_addr = 8'h87;
    #1 check1("sel_other", sfr_sel, 1'b0);
    check8("rdata_other", sfr_rdata, 8'h00);
    sfr_addr = 8'h00;
    step(1);

    // 8-bit transmit of 0xA5, then random bytes in 8- and 9-bit mode
    sfr_write(8'h98, 8'h40);
    check_tx(8'hA5, 1'b0, 1'b0, 16, 1'b1);
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      sfr_write(8'h98, 8'h40);
      check_tx(b, 1'b0, 1'b0, 16, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      b   = 8'($urandom);
      tb8 = 1'($urandom_range(0, 1));
      sfr_write(8'h98, {4'hC, tb8, 3'b000});
      check_tx(b, 1'b1, tb8, 16, 1'b1);
    end

    // SCON write landing on the cycle TI is raised
    sfr_write(8'h98, 8'h40);
    sfr_write(8'h99, 8'h3C);
    repeat (144) @(posedge clk);
    #1;
    sfr_write(8'h98, 8'h50);
    sfr_read(8'h98, rd);
    check8("flag_collision", rd, 8'h52);
    step(24);

    // 9-bit receive, then the same frame filtered by SM2
    rx_case(8'hD0, 8'h3C, 1'b1, 1'b1);
    check8("rx9_spec_scon", m_scon, 8'hD5);
    rx_case(8'hF0, 8'h3C, 1'b0, 1'b1);

    // False start: 4-clock low glitch
    sfr_write(8'h98, 8'h50);
    m_scon = 8'h50;
    rxd_in = 1'b0;
    step(4);
    rxd_in = 1'b1;
    step(40);
    sfr_read(8'h98, rd);
    check8("false_start_scon", rd, m_scon);
    sfr_read(8'h99, rd);
    check8("false_start_sbuf", rd, m_rbuf);

    // REN dropped in the middle of a frame
    sfr_write(8'h98, 8'h50);
    frame = {2'b11, 8'h96, 1'b0};
    drive_bits(frame, 0, 3);
    sfr_write(8'h98, 8'h40);
    m_scon = 8'h40;
    drive_bits(frame, 4, 9);
    step(6);
    sfr_read(8'h98, rd);
    check8("ren_abort_scon", rd, m_scon);
    sfr_read(8'h99, rd);
    check8("ren_abort_sbuf", rd, m_rbuf);

    // Random frames against the acceptance rule
    for (int i = 0; i < 10; i++) begin
      b     = 8'($urandom);
      b9    = 1'($urandom_range(0, 1));
      stopb = ($urandom_range(0, 3) != 0);
      sw    = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0,
               ($urandom_range(0, 3) == 0) ? m_scon[0] : 1'b0};
      rx_case(sw, b, b9, stopb);
    end

    // Baud halving: smod=0 doubles the bit time
    smod = 1'b0;
    sfr_write(8'h98, 8'h40);
    check_tx(8'($urandom), 1'b0, 1'b0, 32, 1'b0);
    smod = 1'b1;

    // Reset in the middle of a transmit frame
    sfr_write(8'h98, 8'h40);
    sfr_write(8'h99, 8'h00);
    step(40);
    check1("pre_reset_txd_low", txd_out, 1'b0);
    reset = 1'b1;
    step(1);
    check1("mid_reset_txd", txd_out, 1'b1);
    check1("mid_reset_irq", irq, 1'b0);
    reset = 1'b0;
    step(160);
    check1("post_reset_txd_idle", txd_out, 1'b1);
    check1("post_reset_irq", irq, 1'b0);
    sfr_read(8'h98, rd);
    check8("post_reset_scon", rd, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
